// File: rtl/bht_predictor.sv
// bht_predictor: branch history table of saturating counters for the IF stage.
// Lookup is combinational from the fetch PC; counters are trained from ROB commit
// using the index captured at fetch. Saturating branch/mispredict statistics.
// Optional gshare indexing (global history XOR PC) is enabled by BHT_GSHARE_EN.
module bht_predictor #(
    parameter int ADDR_WIDTH = 32,
    parameter int INDEX_BITS = 6,
    parameter int CTR_BITS   = 2,
    parameter int GHR_BITS   = 6,
    parameter int STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic [ADDR_WIDTH-1:0] query_pc,
    output logic                  pred_jump,
    output logic [INDEX_BITS-1:0] pred_idx,
    input  logic                  commit_valid,
    input  logic [INDEX_BITS-1:0] commit_idx,
    input  logic                  commit_taken,
    input  logic                  commit_pred,
    output logic [STAT_WIDTH-1:0] stat_branches,
    output logic [STAT_WIDTH-1:0] stat_mispred
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

    // Global history must fit inside the index it is folded into.
    if (GHR_BITS < 1 || GHR_BITS > INDEX_BITS) begin : g_ghr_bits_check
        $error("bht_predictor: GHR_BITS must be in 1..INDEX_BITS");
    end

    logic [CTR_BITS-1:0]   ctr [ENTRIES];
    logic [INDEX_BITS-1:0] pc_idx;
    logic                  update;
    logic                  unused_pc;

    // Commit acceptance: a commit is taken when commit_valid and rdy are both high
    // at a rising edge; there is no back-pressure, so every accepted commit
    // completes in that same cycle and rdy low simply drops commit_valid.
    assign update    = commit_valid & rdy;
    assign pc_idx    = query_pc[INDEX_BITS+1:2];
    assign unused_pc = ^{query_pc[ADDR_WIDTH-1:INDEX_BITS+2], query_pc[1:0]};

`ifdef BHT_GSHARE_EN
    logic [GHR_BITS-1:0]   ghr;
    logic [INDEX_BITS-1:0] ghr_ext;

    // Zero-extend the history to the index width.
    always_comb begin
        ghr_ext                = '0;
        ghr_ext[GHR_BITS-1:0]  = ghr;
    end

    // Committed global history: shift in each accepted resolved direction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr <= '0;
        end else if (update) begin
            ghr <= (ghr << 1) | GHR_BITS'(commit_taken);
        end
    end

    assign pred_idx = pc_idx ^ ghr_ext;
`else
    assign pred_idx = pc_idx;
`endif

    // Prediction reads the pre-update table; no bypass from a same-cycle commit.
    assign pred_jump = ctr[pred_idx][CTR_BITS-1];

    // Counter training from the index recorded at fetch, saturating both ways.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= CTR_WNT;
            end
        end else if (update) begin
            if (commit_taken) begin
                if (ctr[commit_idx] != CTR_MAX) begin
                    ctr[commit_idx] <= ctr[commit_idx] + 1'b1;
                end
            end else begin
                if (ctr[commit_idx] != '0) begin
                    ctr[commit_idx] <= ctr[commit_idx] - 1'b1;
                end
            end
        end
    end

    // Saturating statistics over accepted commits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else if (update) begin
            if (stat_branches != STAT_MAX) begin
                stat_branches <= stat_branches + 1'b1;
            end
            if ((commit_taken != commit_pred) && (stat_mispred != STAT_MAX)) begin
                stat_mispred <= stat_mispred + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bht_predictor.sv
// tb_bht_predictor: scoreboard bench for bht_predictor with a reference counter
// model. A second instance with 2-bit statistics covers stat saturation.
module tb_bht_predictor;

    localparam int AW = 32;
    localparam int IB = 6;
    localparam int GB = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          rdy;
    logic [AW-1:0] query_pc;
    logic          pred_jump;
    logic [IB-1:0] pred_idx;
    logic          commit_valid;
    logic [IB-1:0] commit_idx;
    logic          commit_taken;
    logic          commit_pred;
    logic [31:0]   stat_branches;
    logic [31:0]   stat_mispred;
    logic          pred_jump_s;
    logic [IB-1:0] pred_idx_s;
    logic [1:0]    stat_branches_s;
    logic [1:0]    stat_mispred_s;

    int checks = 0;
    int errors = 0;

    // Scoreboard entries: {pred_jump, pred_idx}
    logic [IB:0] exp_q[$];

    // Reference model state
    int            m_ctr [64];
    logic [GB-1:0] m_ghr;
    int            m_br, m_mis, m_br_s, m_mis_s;

    // clock / reset block
    always #5 clk = ~clk;

    bht_predictor #(.ADDR_WIDTH(AW), .INDEX_BITS(IB), .CTR_BITS(2), .GHR_BITS(GB), .STAT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .query_pc(query_pc),
        .pred_jump(pred_jump), .pred_idx(pred_idx),
        .commit_valid(commit_valid), .commit_idx(commit_idx),
        .commit_taken(commit_taken), .commit_pred(commit_pred),
        .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    bht_predictor #(.ADDR_WIDTH(AW), .INDEX_BITS(IB), .CTR_BITS(2), .GHR_BITS(GB), .STAT_WIDTH(2)) dut_s (
        .clk(clk), .rst(rst), .rdy(rdy), .query_pc(query_pc),
        .pred_jump(pred_jump_s), .pred_idx(pred_idx_s),
        .commit_valid(commit_valid), .commit_idx(commit_idx),
        .commit_taken(commit_taken), .commit_pred(commit_pred),
        .stat_branches(stat_branches_s), .stat_mispred(stat_mispred_s)
    );

    function automatic logic [IB-1:0] m_idx(input logic [AW-1:0] pc);
        logic [IB-1:0] i;
        i = pc[IB+1:2];
`ifdef BHT_GSHARE_EN
        i = i ^ m_ghr;
`endif
        return i;
    endfunction

    // 2-bit counter predicts taken in the upper half (2, 3)
    function automatic logic m_pred(input logic [AW-1:0] pc);
        return m_ctr[m_idx(pc)] >= 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_ctr[i] = 1;
        m_ghr   = '0;
        m_br    = 0;
        m_mis   = 0;
        m_br_s  = 0;
        m_mis_s = 0;
    endtask

    // driver: apply inputs (at negedge) and push the expected lookup result
    task automatic drive(input logic [AW-1:0] pc, input logic cv, input logic [IB-1:0] idx,
                         input logic t, input logic p, input logic r);
        query_pc     = pc;
        commit_valid = cv;
        commit_idx   = idx;
        commit_taken = t;
        commit_pred  = p;
        rdy          = r;
        exp_q.push_back({m_pred(pc), m_idx(pc)});
    endtask

    // driver: advance one clock, mirroring any accepted commit in the model
    task automatic tick();
        @(posedge clk);
        if (rst && rdy && commit_valid) begin
            if (commit_taken) m_ctr[commit_idx] = (m_ctr[commit_idx] == 3) ? 3 : m_ctr[commit_idx] + 1;
            else              m_ctr[commit_idx] = (m_ctr[commit_idx] == 0) ? 0 : m_ctr[commit_idx] - 1;
            m_ghr   = {m_ghr[GB-2:0], commit_taken};
            m_br    = m_br + 1;
            m_br_s  = (m_br_s == 3) ? 3 : m_br_s + 1;
            if (commit_taken != commit_pred) begin
                m_mis   = m_mis + 1;
                m_mis_s = (m_mis_s == 3) ? 3 : m_mis_s + 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [AW-1:0] pcs [3];
        logic [IB:0]   exp;
        pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'hFC;
        rst = 1'b0;
        model_reset();
        #3;
        for (int i = 0; i < 3; i++) begin
            drive(pcs[i], 1'b0, '0, 1'b0, 1'b0, 1'b1);
            #1;
            exp = exp_q.pop_front();
            checks++;
            if (pred_jump !== 1'b0 || {pred_jump, pred_idx} !== exp) begin
                errors++;
                $display("FAIL reset_pred pc=%h got=%b/%0d exp=0/%0d", pcs[i], pred_jump, pred_idx, exp[IB-1:0]);
            end
        end
`ifndef BHT_GSHARE_EN
        checks++;
        if (pred_idx !== 6'd63) begin
            errors++;
            $display("FAIL reset_idx_fc got=%0d exp=63", pred_idx);
        end
`endif
        checks++;
        if (stat_branches !== 32'd0 || stat_mispred !== 32'd0) begin
            errors++;
            $display("FAIL reset_stats got=%0d/%0d exp=0/0", stat_branches, stat_mispred);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_training();
        logic        seq [8];
        logic [IB:0] exp;
        seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            drive(32'h14, 1'b1, 6'd5, seq[i], seq[i], 1'b1);
            #2;
            exp = exp_q.pop_front();
            checks++;
            if ({pred_jump, pred_idx} !== exp) begin
                errors++;
                $display("FAIL training step=%0d got=%b/%0d exp=%b/%0d", i, pred_jump, pred_idx, exp[IB], exp[IB-1:0]);
            end
            tick();
        end
        checks++;
        if (m_ctr[5] != 0 || pred_jump !== 1'b0) begin
            errors++;
            $display("FAIL training_floor got=%b ctr_model=%0d exp=0/0", pred_jump, m_ctr[5]);
        end
    endtask

    task automatic test_same_cycle();
        logic [IB:0] exp;
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            drive(32'h14, (i == 0), 6'd5, 1'b1, 1'b1, 1'b1);
            #2;
            exp = exp_q.pop_front();
            checks++;
            if ({pred_jump, pred_idx} !== exp) begin
                errors++;
                $display("FAIL same_cycle step=%0d got=%b/%0d exp=%b/%0d", i, pred_jump, pred_idx, exp[IB], exp[IB-1:0]);
            end
`ifndef BHT_GSHARE_EN
            checks++;
            if (pred_jump !== (i == 1)) begin
                errors++;
                $display("FAIL same_cycle_bypass step=%0d got=%b exp=%b", i, pred_jump, (i == 1));
            end
`endif
            tick();
        end
    endtask

    task automatic test_rdy();
        logic [IB:0] exp;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive(32'h14, (i < 2), 6'd5, 1'b1, 1'b0, (i != 0));
            #2;
            exp = exp_q.pop_front();
            checks++;
            if ({pred_jump, pred_idx} !== exp) begin
                errors++;
                $display("FAIL rdy_pred step=%0d got=%b/%0d exp=%b/%0d", i, pred_jump, pred_idx, exp[IB], exp[IB-1:0]);
            end
            checks++;
            if (stat_branches !== 32'(m_br) || stat_mispred !== 32'(m_mis)) begin
                errors++;
                $display("FAIL rdy_stats step=%0d got=%0d/%0d exp=%0d/%0d", i, stat_branches, stat_mispred, m_br, m_mis);
            end
            tick();
        end
        checks++;
        if (stat_branches !== 32'd1 || stat_mispred !== 32'd1) begin
            errors++;
            $display("FAIL rdy_applied got=%0d/%0d exp=1/1", stat_branches, stat_mispred);
        end
    endtask

    task automatic test_stats();
        logic tk [4];
        logic pd [4];
        tk = '{1'b1, 1'b0, 1'b1, 1'b1};
        pd = '{1'b1, 1'b1, 1'b0, 1'b1};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive(32'h40, 1'b1, 6'd9, tk[i], pd[i], 1'b1);
            exp_q.pop_front();
            tick();
            if (i == 2) begin
                checks++;
                if (stat_branches !== 32'd3 || stat_mispred !== 32'd2) begin
                    errors++;
                    $display("FAIL stats_three got=%0d/%0d exp=3/2", stat_branches, stat_mispred);
                end
            end
        end
        checks++;
        if (stat_branches !== 32'(m_br) || stat_mispred !== 32'(m_mis) || stat_branches !== 32'd4) begin
            errors++;
            $display("FAIL stats_four got=%0d/%0d exp=%0d/%0d", stat_branches, stat_mispred, m_br, m_mis);
        end
        checks++;
        if (stat_branches_s !== 2'(m_br_s) || stat_mispred_s !== 2'(m_mis_s) || stat_branches_s !== 2'd3) begin
            errors++;
            $display("FAIL stats_saturate got=%0d/%0d exp=%0d/%0d", stat_branches_s, stat_mispred_s, m_br_s, m_mis_s);
        end
    endtask

    task automatic test_back_to_back();
        logic [IB:0] exp;
        logic [AW-1:0] pc;
        apply_reset();
        for (int i = 0; i < 200; i++) begin
            pc = AW'($urandom_range(0, 255));
            drive(pc, 1'($urandom_range(0, 1)), IB'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0));
            #2;
            exp = exp_q.pop_front();
            checks++;
            if ({pred_jump, pred_idx} !== exp || {pred_jump_s, pred_idx_s} !== exp) begin
                errors++;
                $display("FAIL b2b_pred cyc=%0d pc=%h got=%b/%0d exp=%b/%0d", i, pc, pred_jump, pred_idx, exp[IB], exp[IB-1:0]);
            end
            tick();
        end
        checks++;
        if (stat_branches !== 32'(m_br) || stat_mispred !== 32'(m_mis)) begin
            errors++;
            $display("FAIL b2b_stats got=%0d/%0d exp=%0d/%0d", stat_branches, stat_mispred, m_br, m_mis);
        end
    endtask

`ifdef BHT_GSHARE_EN
    task automatic test_gshare();
        logic [IB:0] exp;
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            drive(32'h0, 1'b1, 6'd0, 1'b1, 1'b1, 1'b1);
            exp_q.pop_front();
            tick();
        end
        drive(32'h14, 1'b1, 6'd5, 1'b1, 1'b1, 1'b1);
        #2;
        exp = exp_q.pop_front();
        checks++;
        if (pred_idx !== 6'd6 || {pred_jump, pred_idx} !== exp) begin
            errors++;
            $display("FAIL gshare_idx got=%0d exp=6", pred_idx);
        end
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (pred_idx !== 6'd5 || stat_branches !== 32'd0) begin
            errors++;
            $display("FAIL gshare_reset got=%0d/%0d exp=5/0", pred_idx, stat_branches);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(32'h14, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
        #2;
        exp = exp_q.pop_front();
        checks++;
        if ({pred_jump, pred_idx} !== exp || pred_idx !== 6'd5) begin
            errors++;
            $display("FAIL gshare_after_reset got=%b/%0d exp=%b/5", pred_jump, pred_idx, exp[IB]);
        end
        tick();
    endtask
`endif

    initial begin
        rst = 1'b0; rdy = 1'b1; query_pc = '0;
        commit_valid = 1'b0; commit_idx = '0; commit_taken = 1'b0; commit_pred = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_training();
        test_same_cycle();
        test_rdy();
        test_stats();
        test_back_to_back();
`ifdef BHT_GSHARE_EN
        test_gshare();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
